// File: rtl/digi_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
// NUM_DIGITS/NIBBLE_W/DIGI_W describe the downstream 7-segment translator format:
//   [11:8] one-hot digit enable, [7:4] zero, [3:0] hex nibble.
package digi_pkg;
  localparam int NUM_DIGITS       = 4;
  localparam int NIBBLE_W         = 4;
  localparam int DIGI_W           = 12;
  localparam int DEFAULT_SCAN_DIV = 50000;

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [1:0] k);
    return NUM_DIGITS'(1) << k;
  endfunction

  function automatic logic [NIBBLE_W-1:0] nibble(input logic [15:0] v, input logic [1:0] k);
    return v[{k, 2'b00} +: NIBBLE_W];
  endfunction

  // True when digit k and every digit above it are zero.
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
    return (v >> {k, 2'b00}) == 16'h0000;
  endfunction
endpackage

// File: rtl/digi_scan_if.sv
// Display-scanner bus: control/data from the producer, scan output to the translator.
//   en        : 1 = scanning advances, 0 = freeze
//   value     : four hex digits, digit k = value[4k+3:4k]
//   blank_lz  : 1 = suppress leading-zero digits
//   digi_out  : {onehot enable, 4'b0, nibble}
//   frame_done: one-cycle pulse per completed frame
interface digi_scan_if;
  logic                       en;
  logic [15:0]                value;
  logic                       blank_lz;
  logic [digi_pkg::DIGI_W-1:0] digi_out;
  logic                       frame_done;

  modport master (output en, value, blank_lz, input digi_out, frame_done);
  modport slave  (input en, value, blank_lz, output digi_out, frame_done);
endinterface

// File: rtl/digi_tick.sv
// Dwell prescaler: counts enabled cycles 0..SCAN_DIV-1 and fires tick on the last one.
//   clk, reset (sync, active-high), en (count enable), tick (combinational strobe)
module digi_tick #(
  parameter int SCAN_DIV = digi_pkg::DEFAULT_SCAN_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  // SCAN_DIV=1 still needs a 1-bit register; it just never leaves 0.
  localparam int PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PC_W-1:0] pc_q, pc_d;

  assign tick = en && (pc_q == PC_W'(SCAN_DIV - 1));

  always_comb begin
    pc_d = pc_q;
    if (tick)    pc_d = '0;
    else if (en) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end
endmodule

// File: rtl/digi_scan.sv
// Four-digit hex display scanner. Each digit is shown for SCAN_DIV enabled cycles;
// value is snapshotted only at frame wrap so a frame never tears.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : digi_scan_if slave (en, value, blank_lz in; digi_out, frame_done out)
module digi_scan
  import digi_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic        clk,
  input  logic        reset,
  digi_scan_if.slave  bus
);
  logic              tick, wrap;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       snap_q, snap_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic              fd_q, fd_d;
  logic [NUM_DIGITS-1:0] dig_en;

  digi_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .tick  (tick)
  );

  assign wrap = tick && (idx_q == 2'd3);

  // digi_out is rebuilt from the values being loaded this edge, so the fresh
  // snapshot shows up on digit 0 immediately after the wrap.
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    digi_d = digi_q;
    fd_d   = wrap;
    dig_en = '0;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (wrap) snap_d = bus.value;
      dig_en = onehot(idx_d);
      if (bus.blank_lz && idx_d != 2'd0 && lead_zero(snap_d, idx_d)) dig_en = '0;
      digi_d = {dig_en, NIBBLE_W'(0), nibble(snap_d, idx_d)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 2'd0;
      snap_q <= 16'h0000;
      digi_q <= 12'h100;
      fd_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
      digi_q <= digi_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.digi_out   = digi_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_digi_scan.sv
module tb_digi_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        blank_lz = 1'b0;
  int          errs = 0;
  int          checks = 0;
  bit          chk_on = 1'b0;

  always #5 clk = ~clk;

  digi_scan_if b4 ();
  digi_scan_if b1 ();
  assign b4.en = en;  assign b4.value = value;  assign b4.blank_lz = blank_lz;
  assign b1.en = en;  assign b1.value = value;  assign b1.blank_lz = blank_lz;

  digi_scan #(.SCAN_DIV(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  digi_scan #(.SCAN_DIV(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  // ---------------- behavioural model ----------------
  // cnt = enabled cycles since reset; a dwell boundary is every N of them,
  // the digit shown is (cnt/N) mod 4, and a new frame starts at digit 0.
  int          cnt  [2];
  logic [15:0] msnap[2];
  logic [11:0] exp_d[2];
  logic        exp_f[2];

  function automatic int ndiv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [11:0] disp(input logic [15:0] s, input int dig, input logic blk);
    int nib, upper, on;
    nib   = (s >> (4 * dig)) & 15;
    upper = s >> (4 * dig);
    on    = (blk && dig != 0 && upper == 0) ? 0 : (1 << dig);
    return {on[3:0], 4'h0, nib[3:0]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        cnt[i] = 0; msnap[i] = 16'h0; exp_d[i] = 12'h100; exp_f[i] = 1'b0;
      end else begin
        exp_f[i] = 1'b0;
        if (en) begin
          cnt[i]++;
          if (cnt[i] % ndiv(i) == 0) begin
            int dig;
            dig = (cnt[i] / ndiv(i)) % 4;
            if (dig == 0) msnap[i] = value;
            exp_f[i] = (dig == 0);
            exp_d[i] = disp(msnap[i], dig, blank_lz);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_digi4", b4.digi_out, exp_d[0]);
      chk("model_fd4", {11'b0, b4.frame_done}, {11'b0, exp_f[0]});
      chk("model_digi1", b1.digi_out, exp_d[1]);
      chk("model_fd1", {11'b0, b1.frame_done}, {11'b0, exp_f[1]});
    end
  end

  // ---------------- directed capture helpers ----------------
  logic [11:0] h4[40], h1[40];
  logic        f4[40], f1[40];

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // Records outputs at j = 0..n-1 negedges after reset release; optional value change.
  task automatic capture(input int n, input int chg_at, input logic [15:0] chg_val);
    for (int j = 0; j < n; j++) begin
      h4[j] = b4.digi_out; f4[j] = b4.frame_done;
      h1[j] = b1.digi_out; f1[j] = b1.frame_done;
      if (j == chg_at) value = chg_val;
      @(negedge clk);
    end
  endtask

  initial begin
    @(posedge clk);
    chk_on = 1'b1;

    // Basic frame, value 1234, no blanking
    value = 16'h1234; blank_lz = 1'b0; en = 1'b1;
    do_reset();
    capture(34, -1, 16'h0);
    chk("rst_digi", h4[0], 12'h100);
    chk("rst_fd", {11'b0, f4[0]}, 12'h000);
    chk("first_frame_d0", h4[3], 12'h100);
    chk("first_frame_d1", h4[4], 12'h200);
    chk("wrap_d0", h4[16], 12'h104);
    chk("d0_dwell_end", h4[19], 12'h104);
    chk("d1", h4[20], 12'h203);
    chk("d2", h4[24], 12'h402);
    chk("d3", h4[28], 12'h801);
    chk("fd_pulse16", {11'b0, f4[16]}, 12'h001);
    chk("fd_single", {11'b0, f4[17]}, 12'h000);
    chk("fd_pulse32", {11'b0, f4[32]}, 12'h001);

    // Leading-zero blanking
    value = 16'h00A0; blank_lz = 1'b1;
    do_reset();
    capture(32, -1, 16'h0);
    chk("blk_d0", h4[16], 12'h100);
    chk("blk_d1", h4[20], 12'h20A);
    chk("blk_d2", h4[24], 12'h000);
    chk("blk_d3", h4[28], 12'h000);

    // Value changes mid-frame (digit 1 showing) -> no tearing
    value = 16'h1234; blank_lz = 1'b0;
    do_reset();
    capture(34, 21, 16'hFFFF);
    chk("tear_d2", h4[24], 12'h402);
    chk("tear_d3", h4[28], 12'h801);
    chk("tear_wrap", h4[32], 12'h10F);

    // SCAN_DIV=1 instance
    value = 16'hBEEF;
    do_reset();
    capture(10, -1, 16'h0);
    chk("div1_d0", h1[4], 12'h10F);
    chk("div1_d1", h1[5], 12'h20E);
    chk("div1_d2", h1[6], 12'h40E);
    chk("div1_d3", h1[7], 12'h80B);
    chk("div1_fd4", {11'b0, f1[4]}, 12'h001);
    chk("div1_fd8", {11'b0, f1[8]}, 12'h001);
    chk("div1_fd5", {11'b0, f1[5]}, 12'h000);

    // Randomized run: en gaps, value/blank changes, occasional mid-frame reset
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 5) != 0);
      if (c % 200 < 20) en = 1'b0;
      if ($urandom_range(0, 15) == 0) value = 16'($urandom());
      if ($urandom_range(0, 7) == 0) value = {12'h000, 4'($urandom())};
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
